// File: rtl/vid_rgb2ycbcr.sv
// RGB 4:4:4 to BT.601 limited-range YCbCr 4:2:2 converter.
// Pixels are paired P0/P1; each pair yields one Cb/Y0/Cr/Y1 word three cycles after P1.

module vid_rgb2ycbcr_luma (
  input  logic       clk,
  input  logic       rst,
  input  logic       mul_en_i,
  input  logic       sum_en_i,
  input  logic       out_en_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  logic [15:0] mr_q, mg_q, mb_q;
  logic [15:0] mr_d, mg_d, mb_d;
  logic [16:0] sum_q, sum_d;
  logic [16:0] yv;
  logic [7:0]  y_q, y_d;

  always_comb begin
    mr_d  = 16'(r_i) * 16'd66;
    mg_d  = 16'(g_i) * 16'd129;
    mb_d  = 16'(b_i) * 16'd25;
    sum_d = 17'(mr_q) + 17'(mg_q) + 17'(mb_q) + 17'd128;
    yv    = (sum_q >> 8) + 17'd16;
    if (yv < 17'd16)       y_d = 8'd16;
    else if (yv > 17'd235) y_d = 8'd235;
    else                   y_d = yv[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mr_q  <= '0;
      mg_q  <= '0;
      mb_q  <= '0;
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      if (mul_en_i) begin
        mr_q <= mr_d;
        mg_q <= mg_d;
        mb_q <= mb_d;
      end
      if (sum_en_i) sum_q <= sum_d;
      if (out_en_i) y_q   <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module vid_rgb2ycbcr (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  input  logic       in_sol,
  output logic [7:0] out_cb,
  output logic [7:0] out_y0,
  output logic [7:0] out_cr,
  output logic [7:0] out_y1,
  output logic       out_valid,
  output logic       err_odd
);
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 3;

  logic              phase_q, pend_q, err_q;
  logic [7:0]        r0_q, g0_q, b0_q;
  logic              is_p0, pair_fire;
  logic [STAGES-1:0] vld_pipe_q;

  // P1 only when the phase says so and no start-of-line overrides it.
  assign is_p0     = in_valid & (in_sol | ~phase_q);
  assign pair_fire = in_valid & ~in_sol & phase_q & pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      r0_q       <= '0;
      g0_q       <= '0;
      b0_q       <= '0;
      vld_pipe_q <= '0;
    end else begin
      err_q      <= in_valid & in_sol & pend_q;
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], pair_fire};
      if (is_p0) begin
        r0_q    <= in_r;
        g0_q    <= in_g;
        b0_q    <= in_b;
        phase_q <= 1'b1;
        pend_q  <= 1'b1;
      end else if (in_valid) begin
        phase_q <= 1'b0;
        pend_q  <= 1'b0;
      end
    end
  end

  // Luma: lane 0 takes the held P0, lane 1 the live P1.
  logic [NUM_LANES-1:0][7:0] lane_r, lane_g, lane_b, lane_y;
  assign lane_r = {in_r, r0_q};
  assign lane_g = {in_g, g0_q};
  assign lane_b = {in_b, b0_q};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vid_rgb2ycbcr_luma u_luma (
      .clk      (clk),
      .rst      (rst),
      .mul_en_i (pair_fire),
      .sum_en_i (vld_pipe_q[0]),
      .out_en_i (vld_pipe_q[1]),
      .r_i      (lane_r[l]),
      .g_i      (lane_g[l]),
      .b_i      (lane_b[l]),
      .y_o      (lane_y[l])
    );
  end

  // Chroma on 9-bit pair sums; signs are applied in the sum stage.
  logic [8:0]         rs, gs, bs;
  logic [15:0]        cbr_q, cbg_q, cbb_q, crr_q, crg_q, crb_q;
  logic [15:0]        cbr_d, cbg_d, cbb_d, crr_d, crg_d, crb_d;
  logic signed [19:0] cb_sum_q, cr_sum_q, cb_sum_d, cr_sum_d;
  logic signed [19:0] cb_v, cr_v;
  logic [7:0]         cb_q, cr_q, cb_d, cr_d;
  logic               out_valid_q;

  function automatic logic [7:0] clamp_c(input logic signed [19:0] v);
    if (v < 20'sd16)       return 8'd16;
    else if (v > 20'sd240) return 8'd240;
    else                   return v[7:0];
  endfunction

  always_comb begin
    rs    = 9'(r0_q) + 9'(in_r);
    gs    = 9'(g0_q) + 9'(in_g);
    bs    = 9'(b0_q) + 9'(in_b);
    cbr_d = 16'(rs) * 16'd38;
    cbg_d = 16'(gs) * 16'd74;
    cbb_d = 16'(bs) * 16'd112;
    crr_d = 16'(rs) * 16'd112;
    crg_d = 16'(gs) * 16'd94;
    crb_d = 16'(bs) * 16'd18;
    cb_sum_d = $signed({4'b0, cbb_q}) - $signed({4'b0, cbr_q})
             - $signed({4'b0, cbg_q}) + 20'sd256;
    cr_sum_d = $signed({4'b0, crr_q}) - $signed({4'b0, crg_q})
             - $signed({4'b0, crb_q}) + 20'sd256;
    cb_v = (cb_sum_q >>> 9) + 20'sd128;
    cr_v = (cr_sum_q >>> 9) + 20'sd128;
    cb_d = clamp_c(cb_v);
    cr_d = clamp_c(cr_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cbr_q       <= '0;
      cbg_q       <= '0;
      cbb_q       <= '0;
      crr_q       <= '0;
      crg_q       <= '0;
      crb_q       <= '0;
      cb_sum_q    <= '0;
      cr_sum_q    <= '0;
      cb_q        <= '0;
      cr_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_pipe_q[1];
      if (pair_fire) begin
        cbr_q <= cbr_d;
        cbg_q <= cbg_d;
        cbb_q <= cbb_d;
        crr_q <= crr_d;
        crg_q <= crg_d;
        crb_q <= crb_d;
      end
      if (vld_pipe_q[0]) begin
        cb_sum_q <= cb_sum_d;
        cr_sum_q <= cr_sum_d;
      end
      if (vld_pipe_q[1]) begin
        cb_q <= cb_d;
        cr_q <= cr_d;
      end
    end
  end

  assign out_cb    = cb_q;
  assign out_cr    = cr_q;
  assign out_y0    = lane_y[0];
  assign out_y1    = lane_y[1];
  assign out_valid = out_valid_q;
  assign err_odd   = err_q;
endmodule

// File: tb/tb_vid_rgb2ycbcr.sv
// Scoreboard bench for vid_rgb2ycbcr: directed corner pairs plus a random stream.
module tb_vid_rgb2ycbcr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       in_valid = 1'b0, in_sol = 1'b0;
  logic [7:0] out_cb, out_y0, out_cr, out_y1;
  logic       out_valid, err_odd;

  vid_rgb2ycbcr dut (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_sol(in_sol),
    .out_cb(out_cb), .out_y0(out_y0), .out_cr(out_cr), .out_y1(out_y1),
    .out_valid(out_valid), .err_odd(err_odd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] cb, y0, cr, y1;
  } exp_t;

  exp_t pq[$];
  int   eq[$];
  int   cyc = 0;
  int   checks = 0, failures = 0;
  logic [31:0] last = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model state: number of pixels seen in the current pair.
  int m_cnt = 0;
  int m_r0, m_g0, m_b0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int luma(input int r, input int g, input int b);
    return clampi(16 + ((66*r + 129*g + 25*b + 128) / 256), 16, 235);
  endfunction

  // Floor division by 512 regardless of sign.
  function automatic int fdiv512(input int v);
    int q;
    q = v / 512;
    if (v < 0 && q * 512 != v) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    pq.delete();
    eq.delete();
  endtask

  task automatic send(input int r, input int g, input int b, input bit sol);
    exp_t e;
    int rs, gs, bs;
    in_valid = 1'b1; in_sol = sol;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    if (sol && m_cnt == 1) eq.push_back(cyc + 1);
    if (sol || m_cnt == 0) begin
      m_r0 = r; m_g0 = g; m_b0 = b; m_cnt = 1;
    end else begin
      rs = m_r0 + r; gs = m_g0 + g; bs = m_b0 + b;
      e.cyc = cyc + 3;
      e.y0  = 8'(luma(m_r0, m_g0, m_b0));
      e.y1  = 8'(luma(r, g, b));
      e.cb  = 8'(clampi(128 + fdiv512(-38*rs - 74*gs + 112*bs + 256), 16, 240));
      e.cr  = 8'(clampi(128 + fdiv512(112*rs - 94*gs - 18*bs + 256), 16, 240));
      pq.push_back(e);
      m_cnt = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    model_reset();
    idle(n);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if ({out_cb, out_y0, out_cr, out_y1, out_valid, err_odd} !== 34'd0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got cb=%h y0=%h cr=%h y1=%h v=%b e=%b want all 0",
                 cyc, out_cb, out_y0, out_cr, out_y1, out_valid, err_odd);
      end
      last = '0;
    end else begin
      if (out_valid) begin
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got cb=%h y0=%h cr=%h y1=%h want none",
                   cyc, out_cb, out_y0, out_cr, out_y1);
        end else begin
          e = pq.pop_front();
          if (e.cyc != cyc || {out_cb, out_y0, out_cr, out_y1} !== {e.cb, e.y0, e.cr, e.y1}) begin
            failures++;
            $display("FAIL pair cyc=%0d got cb=%0d y0=%0d cr=%0d y1=%0d want cyc=%0d cb=%0d y0=%0d cr=%0d y1=%0d",
                     cyc, out_cb, out_y0, out_cr, out_y1, e.cyc, e.cb, e.y0, e.cr, e.y1);
          end
          last = {e.cb, e.y0, e.cr, e.y1};
        end
      end else begin
        checks++;
        if ({out_cb, out_y0, out_cr, out_y1} !== last) begin
          failures++;
          $display("FAIL hold cyc=%0d got %h want %h", cyc,
                   {out_cb, out_y0, out_cr, out_y1}, last);
        end
        if (pq.size() > 0 && pq[0].cyc <= cyc) begin
          checks++; failures++;
          $display("FAIL missing_valid cyc=%0d got none want pair at cyc=%0d", cyc, pq[0].cyc);
          void'(pq.pop_front());
        end
      end
      if (err_odd) begin
        checks++;
        if (eq.size() == 0 || eq[0] != cyc) begin
          failures++;
          $display("FAIL err_odd cyc=%0d got pulse want %0s", cyc,
                   eq.size() == 0 ? "none" : "later pulse");
        end
        if (eq.size() > 0 && eq[0] <= cyc) void'(eq.pop_front());
      end else if (eq.size() > 0 && eq[0] <= cyc) begin
        checks++; failures++;
        $display("FAIL err_odd_missing cyc=%0d got 0 want pulse", cyc);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, c;
    idle(3);
    rst = 1'b0;
    idle(2);
    // White, black, red pairs
    send(255, 255, 255, 1); send(255, 255, 255, 0); idle(4);
    send(0, 0, 0, 1);       send(0, 0, 0, 0);       idle(4);
    send(255, 0, 0, 1);     send(255, 0, 0, 0);     idle(4);
    send(255, 0, 0, 0);     idle(5); send(255, 0, 0, 0); idle(4);
    // Continuous 8-pixel line
    for (int i = 0; i < 8; i++)
      send($urandom_range(255), $urandom_range(255), $urandom_range(255), i == 0);
    idle(5);
    // Orphan P0 dropped by start of line
    send(10, 200, 30, 1); send(40, 50, 60, 1); send(70, 80, 90, 0); idle(5);
    // Reset right after a P1: in-flight pair vanishes
    send(1, 2, 3, 0); send(4, 5, 6, 0);
    pulse_reset(1);
    send(100, 150, 200, 1); send(20, 30, 40, 0); idle(5);
    // Reset with a pending P0; first pixel after release is P0 even with sol=0
    send(9, 9, 9, 1);
    pulse_reset(2);
    send(200, 10, 10, 0); send(10, 10, 200, 0); idle(5);
    // Random stream, sol sometimes toggled on idle cycles too
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) < 7) begin
        a = $urandom_range(255); b = $urandom_range(255); c = $urandom_range(255);
        if ($urandom_range(3) == 0) begin
          a = ($urandom_range(1) == 1) ? 255 : 0;
          c = ($urandom_range(1) == 1) ? 255 : 0;
        end
        send(a, b, c, $urandom_range(7) == 0);
      end else begin
        in_sol = 1'(($urandom_range(1)));
        idle(1);
        in_sol = 1'b0;
      end
      if (i == 300) pulse_reset(1);
    end
    idle(8);
    checks++;
    if (pq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL drain got pairs=%0d errs=%0d outstanding want 0", pq.size(), eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vid_rgb2ycbcr.md
VID_RGB2YCBCR -- requirements
Module: vid_rgb2ycbcr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_r, in_g, in_b  in  8 each  RGB pixel, full range 0..255
- in_valid  in  1  pixel present this cycle
- in_sol  in  1  qualified by in_valid; pixel is first of a line
- out_cb, out_y0, out_cr, out_y1  out  8 each  4:2:2 pixel pair, BT.601 limited range
- out_valid  out  1  single-cycle strobe, pair valid
- err_odd  out  1  single-cycle strobe, half pair dropped
REQ-003 The block SHALL have no parameters and no backpressure; it SHALL accept one pixel per cycle indefinitely.

Function
REQ-004 A phase bit SHALL count accepted pixels (in_valid=1): even pixel = P0, odd pixel = P1; the bit SHALL toggle per accepted pixel and be unaffected by idle cycles.
REQ-005 in_sol=1 with in_valid=1 SHALL force that pixel to P0 regardless of the phase bit.
REQ-006 If in_sol arrives while a P0 is pending, the block SHALL discard the pending P0, pulse err_odd for 1 cycle on the next cycle, and treat the new pixel as P0.
REQ-007 P0 RGB SHALL be held in a register until its P1 arrives; gaps of any length between P0 and P1 SHALL be tolerated.
REQ-008 Luma per pixel SHALL be Y = 16 + ((66R + 129G + 25B + 128) >> 8), unsigned.
REQ-009 Chroma SHALL use pair sums Rs=R0+R1, Gs=G0+G1, Bs=B0+B1 (9 bit):
- Cb = 128 + ((-38Rs - 74Gs + 112Bs + 256) >>> 9)
- Cr = 128 + ((112Rs - 94Gs - 18Bs + 256) >>> 9)
- >>> is an arithmetic (floor) shift; intermediates SHALL be at least 18-bit signed.
REQ-010 Outputs SHALL be clamped: Y to 16..235, Cb/Cr to 16..240.
REQ-011 The datapath SHALL be a 3-stage pipeline: multiply, sum, round/clamp/register. out_valid SHALL assert exactly 3 cycles after the cycle P1 was accepted (P1 at cycle T -> out_valid at T+3).
REQ-012 out_cb/out_y0/out_cr/out_y1 SHALL hold their last value while out_valid=0.
REQ-013 Back-to-back pairs (in_valid continuously 1) SHALL produce out_valid on every second cycle with no loss.
REQ-014 Pairs already in the pipeline when in_sol occurs SHALL complete normally.

Reset
REQ-015 While rst=1, all outputs, pipeline valid bits and the pending-P0 flag SHALL be 0 and the phase bit SHALL be P0.
REQ-016 Reset asserted mid-operation SHALL discard the pending P0 and all in-flight pairs; no out_valid or err_odd SHALL be produced for them after release.
REQ-017 The first accepted pixel after reset release SHALL be P0 regardless of in_sol.

Verification
REQ-018 White pair (255,255,255)x2, in_sol on P0 -> 3 cycles after P1: out_y0=out_y1=235, out_cb=out_cr=128, out_valid for 1 cycle.
REQ-019 Black pair (0,0,0)x2 -> Y0=Y1=16, Cb=Cr=128.
REQ-020 Red pair (255,0,0)x2 -> Y0=Y1=82, Cb=90, Cr=240; repeat with 5 idle cycles between P0 and P1 -> same values, out_valid at P1+3.
REQ-021 Continuous stream of 8 pixels with in_valid=1 -> 4 out_valid strobes spaced 2 cycles apart, first at cycle of pixel 1 + 3.
REQ-022 Pixel A (P0), then pixel B with in_sol=1, then pixel C -> err_odd pulses once; one pair (B,C) is output; A never appears.
REQ-023 rst pulsed one cycle after a P1 is accepted -> no out_valid follows; next two pixels form a normal pair.
